mem_loader: RTL and testbench

- Bus initiator that drives the address/data_in/write_enable/data_out interface of the memory decoder.
- Accepts a byte stream over a valid/ready handshake and writes it into consecutive SRAM addresses from BASE_ADDR.
- Then reads the image back and checks it against checksums accumulated during the load.
- Holds the CPU off the bus (cpu_hold) while it owns memory; used to boot program images into the 256-byte space.

---
 rtl/mem_loader.sv | 121 ++++++++++++
 tb/tb_mem_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: boot loader that streams a byte image into SRAM from BASE_ADDR,
// then reads it back and compares sum/xor checksums before releasing the bus.
module mem_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter logic [7:0] LAST_ADDR = 8'hFE
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic [7:0] mem_address,
    output logic [7:0] mem_data_out,
    output logic       mem_write_enable,
    input  logic [7:0] mem_data_in,
    output logic       busy,
    output logic       cpu_hold,
    output logic       done,
    output logic       error,
    output logic [7:0] error_addr,
    output logic [7:0] checksum
);
    typedef enum logic [2:0] {IDLE, LOAD, VERIFY, CHECK, DONE, FAIL} state_t;
    state_t state, state_nx;
    logic [7:0] wptr, endptr, rptr, sum, xsum, rsum, rxsum, fsum, fxsum;
    logic rd_valid, rd_issued, hs, go, pass, owns_bus;

    assign byte_ready = state == LOAD;
    assign hs = byte_valid & byte_ready;
    assign go = start & (state == IDLE || state == DONE || state == FAIL);
    // The first VERIFY cycle still carries the final write, so only later cycles present read addresses.
    assign rd_issued = state == VERIFY && !mem_write_enable;
    assign fsum = rsum + mem_data_in;
    assign fxsum = rxsum ^ mem_data_in;
    assign pass = fsum == sum && fxsum == xsum;
    assign owns_bus = state_nx == LOAD || state_nx == VERIFY || state_nx == CHECK;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, FAIL: state_nx = start ? LOAD : state;
            LOAD:   state_nx = !hs ? LOAD : byte_last ? VERIFY : wptr == LAST_ADDR ? FAIL : LOAD;
            VERIFY: state_nx = rd_issued && mem_address == endptr ? CHECK : VERIFY;
            CHECK:  state_nx = pass ? DONE : FAIL;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
            wptr <= '0;
            endptr <= '0;
            rptr <= '0;
            sum <= '0;
            xsum <= '0;
            rsum <= '0;
            rxsum <= '0;
            rd_valid <= 1'b0;
            mem_address <= '0;
            mem_data_out <= '0;
            mem_write_enable <= 1'b0;
            busy <= 1'b0;
            cpu_hold <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            error_addr <= '0;
            checksum <= '0;
        end else begin
            state <= state_nx;
            busy <= owns_bus;
            cpu_hold <= owns_bus;
            mem_write_enable <= hs;
            rd_valid <= rd_issued;
            if (go) begin
                wptr <= BASE_ADDR;
                rptr <= BASE_ADDR;
                sum <= '0;
                xsum <= '0;
                rsum <= '0;
                rxsum <= '0;
                done <= 1'b0;
                error <= 1'b0;
                error_addr <= '0;
                checksum <= '0;
            end
            if (hs) begin
                mem_address <= wptr;
                mem_data_out <= byte_in;
                sum <= sum + byte_in;
                xsum <= xsum ^ byte_in;
                wptr <= wptr + 8'd1;
                if (byte_last)
                    endptr <= wptr;
                else if (wptr == LAST_ADDR) begin
                    error <= 1'b1;
                    error_addr <= 8'hFF;
                    checksum <= sum + byte_in;
                end
            end
            if (state == VERIFY) begin
                if (state_nx == VERIFY) begin
                    mem_address <= rptr;
                    rptr <= rptr + 8'd1;
                end
                if (rd_valid) begin
                    rsum <= fsum;
                    rxsum <= fxsum;
                end
            end
            if (state == CHECK) begin
                done <= pass;
                error <= !pass;
                checksum <= sum;
                if (!pass) error_addr <= endptr;
            end
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: table-driven loads against a synchronous SRAM model, with a
// write scoreboard and a hand-written async-reset-abort sequence.
module tb_mem_loader;
    logic clk = 1'b0, res = 1'b0, start = 1'b0;
    logic byte_valid = 1'b0, byte_last = 1'b0;
    logic [7:0] byte_in = 8'h00, mem_data_in = 8'h00;
    logic byte_ready, mem_write_enable, busy, cpu_hold, done, error;
    logic [7:0] mem_address, mem_data_out, error_addr, checksum;
    logic [7:0] mem [256];
    logic [15:0] exp_q [$];
    logic [15:0] mon_e;
    logic corrupt = 1'b0;
    int vectors = 0, miscompares = 0, ff_writes = 0;

    typedef struct {
        int n; logic [7:0] first; logic [7:0] step;
        bit last; bit gaps; bit corrupt; bit chk_cs;
        bit exp_done; bit exp_err; logic [7:0] exp_ea; logic [7:0] exp_cs; int exp_acc;
    } vec_t;

    mem_loader dut (
        .clk(clk), .res(res), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_last(byte_last), .byte_ready(byte_ready), .mem_address(mem_address),
        .mem_data_out(mem_data_out), .mem_write_enable(mem_write_enable),
        .mem_data_in(mem_data_in), .busy(busy), .cpu_hold(cpu_hold), .done(done),
        .error(error), .error_addr(error_addr), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // SRAM: synchronous write, read data appears the cycle after the address
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address] <= mem_data_out;
        mem_data_in <= mem[mem_address] ^ {7'd0, corrupt && mem_address == 8'h01};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp_v);
        end
    endtask

    always @(negedge clk) if (res && mem_write_enable) begin
        if (mem_address == 8'hFF) ff_writes++;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0h data %0h want no write", mem_address, mem_data_out);
        end else begin
            mon_e = exp_q.pop_front();
            chk("write_addr_data", {16'd0, mem_address, mem_data_out}, {16'd0, mon_e});
        end
    end

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("cpu_hold_after_start", cpu_hold, 1);
        chk("done_cleared", done, 0);
        chk("error_cleared", error, 0);
    endtask

    task automatic run_load(input int n, input logic [7:0] first, input logic [7:0] step,
                            input bit last, input bit gaps, output int acc);
        logic [7:0] d;
        int waited;
        d = first;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            byte_valid = 1'b1;
            byte_in = d;
            byte_last = last && i == n - 1;
            waited = 0;
            while (!byte_ready && waited < 4) begin
                @(negedge clk);
                waited++;
            end
            if (!byte_ready) break;
            exp_q.push_back({8'h00 + acc[7:0], d});
            acc++;
            @(negedge clk);
            byte_valid = 1'b0;
            byte_last = 1'b0;
            d = d + step;
        end
        byte_valid = 1'b0;
        byte_last = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("finish_in_time", busy, 0);
        chk("cpu_hold_released", cpu_hold, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_error_addr"}, error_addr, 0);
        chk({tag, "_checksum"}, checksum, 0);
        chk({tag, "_we"}, mem_write_enable, 0);
        chk({tag, "_address"}, mem_address, 0);
        chk({tag, "_data_out"}, mem_data_out, 0);
        chk({tag, "_byte_ready"}, byte_ready, 0);
    endtask

    initial begin
        vec_t v [6];
        int acc;
        v[0] = '{3,   8'h11, 8'h11, 1, 0, 0, 1, 1, 0, 8'h00, 8'h66, 3};
        v[1] = '{1,   8'hA5, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'hA5, 1};
        v[2] = '{255, 8'h00, 8'h01, 1, 0, 0, 1, 1, 0, 8'h00, 8'h81, 255};
        v[3] = '{256, 8'h00, 8'h01, 0, 0, 0, 0, 0, 1, 8'hFF, 8'h00, 255};
        v[4] = '{4,   8'h10, 8'h10, 1, 0, 1, 1, 0, 1, 8'h03, 8'hA0, 4};
        v[5] = '{5,   8'h05, 8'h07, 1, 1, 0, 1, 1, 0, 8'h00, 8'h5F, 5};
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        res = 1'b1;
        for (int i = 0; i < 6; i++) begin
            corrupt = v[i].corrupt;
            ff_writes = 0;
            do_start();
            run_load(v[i].n, v[i].first, v[i].step, v[i].last, v[i].gaps, acc);
            chk("bytes_accepted", acc, v[i].exp_acc);
            wait_idle();
            repeat (2) @(negedge clk);
            chk("done", done, v[i].exp_done);
            chk("error", error, v[i].exp_err);
            if (v[i].exp_err) chk("error_addr", error_addr, v[i].exp_ea);
            if (v[i].chk_cs) chk("checksum", checksum, v[i].exp_cs);
            chk("writes_drained", exp_q.size(), 0);
            chk("no_ff_write", ff_writes, 0);
        end
        corrupt = 1'b0;
        // abort a gapped load with an asynchronous reset while a write is on the bus
        do_start();
        repeat (2) @(negedge clk);
        byte_valid = 1'b1;
        byte_in = 8'h5A;
        @(posedge clk);
        #2;
        byte_valid = 1'b0;
        chk("we_before_reset", mem_write_enable, 1);
        res = 1'b0;
        #1;
        check_all_zero("abort");
        exp_q.delete();
        repeat (2) @(negedge clk);
        res = 1'b1;
        do_start();
        run_load(3, 8'h11, 8'h11, 1, 1, acc);
        chk("reload_accepted", acc, 3);
        wait_idle();
        chk("reload_done", done, 1);
        chk("reload_error", error, 0);
        chk("reload_checksum", checksum, 8'h66);
        chk("reload_writes_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
